// File: rtl/mem_verify.sv
// Read-back checker for the identity-initialised S-memory: walks START_ADDR..END_ADDR,
// compares each word with its own address and reports count and first failing address.
module mem_verify #(
  parameter logic [7:0] START_ADDR = 8'h00,
  parameter logic [7:0] END_ADDR   = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_flag,
  output logic [7:0] address,
  output logic       wren,
  input  logic [7:0] q,
  output logic       done_flag,
  output logic       pass,
  output logic [8:0] error_count,
  output logic       err_seen,
  output logic [7:0] first_err_addr
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] counter_q, counter_d;
  logic [8:0] errCount_q, errCount_d;
  logic       errSeen_q, errSeen_d;
  logic [7:0] firstErr_q, firstErr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      counter_q  <= START_ADDR;
      errCount_q <= '0;
      errSeen_q  <= 1'b0;
      firstErr_q <= '0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      errCount_q <= errCount_d;
      errSeen_q  <= errSeen_d;
      firstErr_q <= firstErr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    errCount_d = errCount_q;
    errSeen_d  = errSeen_q;
    firstErr_d = firstErr_q;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == IDLE) counter_d = START_ADDR;
        if (start_flag) begin
          state_d    = ADDR;
          counter_d  = START_ADDR;
          errCount_d = '0;
          errSeen_d  = 1'b0;
          firstErr_d = '0;
        end
      end
      ADDR: state_d = WAIT;
      WAIT: state_d = CHECK;
      CHECK: begin
        // The RAM read of counter_q has settled by now, so q belongs to this address.
        if (q != counter_q) begin
          errCount_d = errCount_q + 9'd1;
          if (!errSeen_q) begin
            errSeen_d  = 1'b1;
            firstErr_d = counter_q;
          end
        end
        if (counter_q == END_ADDR) begin
          state_d = DONE;
        end else begin
          counter_d = counter_q + 8'd1;
          state_d   = ADDR;
        end
      end
      default: begin
        state_d   = IDLE;
        counter_d = START_ADDR;
      end
    endcase
  end

  assign address        = counter_q;
  assign wren           = 1'b0;
  assign done_flag      = (state_q == DONE);
  assign pass           = (state_q == DONE) && (errCount_q == 9'd0);
  assign error_count    = errCount_q;
  assign err_seen       = errSeen_q;
  assign first_err_addr = firstErr_q;

endmodule

// File: tb/tb_mem_verify.sv
// Self-checking bench for mem_verify: table-driven RAM patterns, randomized corruption
// against a reference count model, plus reset-mid-pass and restart-from-DONE sequences.
module tb_mem_verify;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_flag;
  logic [7:0] address;
  logic       wren;
  logic [7:0] q;
  logic       done_flag;
  logic       pass;
  logic [8:0] error_count;
  logic       err_seen;
  logic [7:0] first_err_addr;

  int assertCount = 0;
  int failCount   = 0;
  int wrenHigh    = 0;

  logic [7:0] mem [256];

  always #5 clk = ~clk;

  mem_verify dut (
    .clk           (clk),
    .reset         (reset),
    .start_flag    (start_flag),
    .address       (address),
    .wren          (wren),
    .q             (q),
    .done_flag     (done_flag),
    .pass          (pass),
    .error_count   (error_count),
    .err_seen      (err_seen),
    .first_err_addr(first_err_addr)
  );

  // RAM with registered address and one cycle of read latency
  always @(posedge clk) q <= mem[address];

  always @(negedge clk) if (wren !== 1'b0) wrenHigh++;

  typedef struct {
    string     name;
    bit        allZero;
    int        nOver;
    logic [7:0] a0, d0, a1, d1;
    bit        expPass;
    int        expCnt;
    bit        expSeen;
    logic [7:0] expFirst;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic fillIdentity();
    for (int a = 0; a < 256; a++) mem[a] = 8'(a);
  endtask

  // Reference: a pass over 0x00..0xFF counts every location whose word differs from its address
  function automatic void refModel(output int cnt, output int first);
    cnt = 0;
    first = -1;
    for (int a = 0; a < 256; a++) begin
      if (mem[a] != 8'(a)) begin
        cnt++;
        if (first < 0) first = a;
      end
    end
  endfunction

  task automatic applyStimulus(input string tag, output int cycles);
    @(negedge clk);
    start_flag = 1'b1;
    @(posedge clk);
    #1;
    start_flag = 1'b0;
    checkOutput({tag, ".doneLowAfterStart"}, done_flag, 0);
    checkOutput({tag, ".countClearedAtStart"}, error_count, 0);
    checkOutput({tag, ".seenClearedAtStart"}, err_seen, 0);
    cycles = -1;
    for (int n = 1; n <= 1000; n++) begin
      @(posedge clk);
      #1;
      if (done_flag === 1'b1) begin
        cycles = n;
        break;
      end
    end
    checkOutput({tag, ".doneLatency"}, cycles, 768);
  endtask

  task automatic checkResults(input string tag, input bit expPass, input int expCnt,
                              input bit expSeen, input logic [7:0] expFirst);
    checkOutput({tag, ".done"}, done_flag, 1);
    checkOutput({tag, ".pass"}, pass, expPass);
    checkOutput({tag, ".errorCount"}, error_count, expCnt);
    checkOutput({tag, ".errSeen"}, err_seen, expSeen);
    if (expSeen) checkOutput({tag, ".firstErrAddr"}, first_err_addr, expFirst);
    checkOutput({tag, ".addrAtEnd"}, address, 8'hFF);
  endtask

  vec_t vecs[4];

  initial begin
    int cycles, cnt, first;

    vecs[0] = '{"identity",  1'b0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 0,   1'b0, 8'h00};
    vecs[1] = '{"bad37",     1'b0, 1, 8'h37, 8'h00, 8'h00, 8'h00, 1'b0, 1,   1'b1, 8'h37};
    vecs[2] = '{"badEnds",   1'b0, 2, 8'h00, 8'h01, 8'hFF, 8'h00, 1'b0, 2,   1'b1, 8'h00};
    vecs[3] = '{"allZero",   1'b1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 255, 1'b1, 8'h01};

    reset = 1'b1;
    start_flag = 1'b0;
    fillIdentity();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.address", address, 8'h00);
    checkOutput("reset.done", done_flag, 0);
    checkOutput("reset.pass", pass, 0);
    checkOutput("reset.errorCount", error_count, 0);
    checkOutput("reset.errSeen", err_seen, 0);
    checkOutput("reset.firstErr", first_err_addr, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].allZero) for (int a = 0; a < 256; a++) mem[a] = 8'h00;
      else fillIdentity();
      if (vecs[i].nOver >= 1) mem[vecs[i].a0] = vecs[i].d0;
      if (vecs[i].nOver >= 2) mem[vecs[i].a1] = vecs[i].d1;
      applyStimulus(vecs[i].name, cycles);
      checkResults(vecs[i].name, vecs[i].expPass, vecs[i].expCnt, vecs[i].expSeen, vecs[i].expFirst);
      repeat (3) @(posedge clk);
      #1;
      checkOutput({vecs[i].name, ".addrNoWrap"}, address, 8'hFF);
      checkOutput({vecs[i].name, ".doneHolds"}, done_flag, 1);
    end

    for (int r = 0; r < 4; r++) begin
      fillIdentity();
      for (int k = $urandom_range(5, 1); k > 0; k--) mem[$urandom_range(255, 0)] = 8'($urandom);
      refModel(cnt, first);
      applyStimulus($sformatf("rand%0d", r), cycles);
      checkResults($sformatf("rand%0d", r), cnt == 0, cnt, cnt != 0, 8'(first));
    end

    // Restart from DONE holding one error: results clear and the repaired RAM passes
    fillIdentity();
    mem[8'h37] = 8'h00;
    applyStimulus("preRestart", cycles);
    checkResults("preRestart", 1'b0, 1, 1'b1, 8'h37);
    mem[8'h37] = 8'h37;
    applyStimulus("restart", cycles);
    checkResults("restart", 1'b1, 0, 1'b0, 8'h00);

    // Reset mid-pass at address 0x80 with an error already recorded
    mem[8'h10] = 8'h00;
    @(negedge clk);
    start_flag = 1'b1;
    @(posedge clk);
    #1;
    start_flag = 1'b0;
    cycles = -1;
    for (int n = 0; n < 1000; n++) begin
      if (address == 8'h80) begin
        cycles = n;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("midPass.reachedAddr80", address, 8'h80);
    checkOutput("midPass.errorBeforeReset", error_count, 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midReset.address", address, 8'h00);
    checkOutput("midReset.done", done_flag, 0);
    checkOutput("midReset.pass", pass, 0);
    checkOutput("midReset.errorCount", error_count, 0);
    checkOutput("midReset.errSeen", err_seen, 0);
    checkOutput("midReset.firstErr", first_err_addr, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idleHold.address", address, 8'h00);
    checkOutput("idleHold.done", done_flag, 0);
    mem[8'h10] = 8'h10;
    applyStimulus("afterReset", cycles);
    checkResults("afterReset", 1'b1, 0, 1'b0, 8'h00);

    checkOutput("wrenAlwaysLow", wrenHigh, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
